axis_fir_param: RTL

//  Parametrised, run-time reprogrammable AXI-Stream FIR filter; the next generation of the fixed 15-tap LPF.

---
 rtl/axis_fir_param.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/axis_fir_param.sv
// axis_fir_param: reprogrammable AXI-Stream FIR with double-buffered coefficients, tlast flush and output saturation.
// Latency: 3 clk from the cycle a beat is accepted (delay line, products, adder tree/saturate into output regs).
// Backpressure: every stage holds while the output beat is stalled; s_axis_fir_tready follows immediately.
//
// Ports:
//   clk, reset                    rising-edge clock, synchronous active-low reset
//   s_axis_fir_t{data,valid,last} input sample stream; s_axis_fir_tready = reset && pipeline advance
//   m_axis_fir_t{data,valid,last,keep}, m_axis_fir_tready  filtered output stream
//   coef_wr_en/addr/data          write one tap of the shadow coefficient bank
//   coef_commit                   copy the shadow bank (including a same-cycle write) into the active bank
//   sat_flag                      set with an output beat whose value was clamped
module axis_fir_param #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int NTAPS    = 15,
  parameter int OUT_W    = 32,
  parameter int SHIFT    = 0,
  parameter int FLUSH_EN = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          s_axis_fir_tdata,
  input  logic                       s_axis_fir_tvalid,
  input  logic                       s_axis_fir_tlast,
  output logic                       s_axis_fir_tready,
  output logic [OUT_W-1:0]           m_axis_fir_tdata,
  output logic                       m_axis_fir_tvalid,
  output logic                       m_axis_fir_tlast,
  output logic [OUT_W/8-1:0]         m_axis_fir_tkeep,
  input  logic                       m_axis_fir_tready,
  input  logic                       coef_wr_en,
  input  logic [$clog2(NTAPS)-1:0]   coef_wr_addr,
  input  logic [COEF_W-1:0]          coef_wr_data,
  input  logic                       coef_commit,
  output logic                       sat_flag
);

  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + $clog2(NTAPS);
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  // Output range limits expressed at the extended width so the comparison is lossless.
  localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

  // Coefficient banks
  logic signed [COEF_W-1:0] shadow_q [NTAPS];
  logic signed [COEF_W-1:0] shadow_d [NTAPS];
  logic signed [COEF_W-1:0] active_q [NTAPS];
  logic signed [COEF_W-1:0] active_d [NTAPS];

  // Stage 0: delay line
  logic signed [DATA_W-1:0] dly_q [NTAPS];
  logic signed [DATA_W-1:0] dly_d [NTAPS];
  logic                     flush_pend_q, flush_pend_d;
  logic                     s0_vld_q, s0_last_q;

  // Stage 1: products
  logic signed [PW-1:0]     prod_q [NTAPS];
  logic signed [PW-1:0]     prod_d [NTAPS];
  logic                     s1_vld_q, s1_last_q;

  // Stage 2: sum, shift, saturate
  logic signed [ACC_W-1:0]  acc_sum, acc_shf;
  logic signed [EXT_W-1:0]  acc_ext;
  logic [OUT_W-1:0]         out_d;
  logic                     sat_d;

  logic [OUT_W-1:0]         m_tdata_q;
  logic                     m_tvalid_q, m_tlast_q, sat_q;
  logic [OUT_W/8-1:0]       m_tkeep_q;

  logic adv, s_acc;

  assign adv               = !m_tvalid_q || m_axis_fir_tready;
  assign s_axis_fir_tready = reset && adv;
  assign s_acc             = s_axis_fir_tvalid && s_axis_fir_tready;

  assign m_axis_fir_tdata  = m_tdata_q;
  assign m_axis_fir_tvalid = m_tvalid_q;
  assign m_axis_fir_tlast  = m_tlast_q;
  assign m_axis_fir_tkeep  = m_tkeep_q;
  assign sat_flag          = sat_q;

  // A write in the commit cycle is merged before the copy so it lands in the active bank.
  always_comb begin
    shadow_d = shadow_q;
    if (coef_wr_en && (int'(coef_wr_addr) < NTAPS)) begin
      shadow_d[coef_wr_addr] = coef_wr_data;
    end
    active_d = coef_commit ? shadow_d : active_q;
  end

  // After a tlast beat, the next accepted beat enters an otherwise zeroed line.
  always_comb begin
    dly_d        = dly_q;
    flush_pend_d = flush_pend_q;
    if (s_acc) begin
      for (int k = NTAPS - 1; k > 0; k--) begin
        dly_d[k] = ((FLUSH_EN != 0) && flush_pend_q) ? '0 : dly_q[k-1];
      end
      dly_d[0]     = s_axis_fir_tdata;
      flush_pend_d = (FLUSH_EN != 0) && s_axis_fir_tlast;
    end
  end

  // All taps of one sample are multiplied in the same cycle against one bank.
  always_comb begin
    for (int k = 0; k < NTAPS; k++) begin
      prod_d[k] = PW'(dly_q[k]) * PW'(active_q[k]);
    end
  end

  always_comb begin
    acc_sum = '0;
    for (int k = 0; k < NTAPS; k++) begin
      acc_sum = acc_sum + ACC_W'(prod_q[k]);
    end
    acc_shf = acc_sum >>> SHIFT;
    acc_ext = EXT_W'(acc_shf);
    sat_d   = 1'b0;
    if (acc_ext > MAX_V) begin
      out_d = {1'b0, {(OUT_W-1){1'b1}}};
      sat_d = 1'b1;
    end else if (acc_ext < MIN_V) begin
      out_d = {1'b1, {(OUT_W-1){1'b0}}};
      sat_d = 1'b1;
    end else begin
      out_d = acc_ext[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_q     <= '{default: '0};
      active_q     <= '{default: '0};
      dly_q        <= '{default: '0};
      prod_q       <= '{default: '0};
      flush_pend_q <= 1'b0;
      s0_vld_q     <= 1'b0;
      s0_last_q    <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      m_tdata_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tkeep_q    <= '0;
      sat_q        <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      dly_q        <= dly_d;
      flush_pend_q <= flush_pend_d;
      m_tkeep_q    <= '1;
      if (adv) begin
        s0_vld_q   <= s_acc;
        s0_last_q  <= s_axis_fir_tlast;
        prod_q     <= prod_d;
        s1_vld_q   <= s0_vld_q;
        s1_last_q  <= s0_last_q;
        m_tdata_q  <= out_d;
        m_tvalid_q <= s1_vld_q;
        m_tlast_q  <= s1_last_q;
        sat_q      <= sat_d;
      end
    end
  end

endmodule
